// File: rtl/qbus_dma_arb_if.sv
// Signal bundle between the Q-bus DMA arbiter and the CPU bus-cycle logic / Q-bus pins.
// slave = arbiter view, master = the surrounding CPU wrapper and pad ring.
interface qbus_dma_arb_if;
  logic cpu_busy;
  logic cpu_req;
  logic cpu_hold;
  logic cpu_bus_dis;
  logic pin_dmr_n;
  logic pin_sack_n;
  logic pin_sync_n;
  logic pin_rply_n;
  logic pin_dmgo_n;
  logic dma_act;
  logic gnt_tmo;

  modport slave (
    input  cpu_busy, cpu_req, pin_dmr_n, pin_sack_n, pin_sync_n, pin_rply_n,
    output cpu_hold, cpu_bus_dis, pin_dmgo_n, dma_act, gnt_tmo
  );

  modport master (
    output cpu_busy, cpu_req, pin_dmr_n, pin_sack_n, pin_sync_n, pin_rply_n,
    input  cpu_hold, cpu_bus_dis, pin_dmgo_n, dma_act, gnt_tmo
  );
endinterface

// File: rtl/qbus_dma_arb.sv
// Q-bus DMA arbiter: DMR/DMGO/SACK handshake, CPU stall and bus release for the F-11 wrapper.
// All outputs are registered decodes of the next state.
module qbus_dma_arb #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GNT_TIMEOUT = 64
) (
  input logic            pin_clk,
  input logic            reset,
  qbus_dma_arb_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FAIR     = 3'd1;
  localparam logic [2:0] S_WAIT_CPU = 3'd2;
  localparam logic [2:0] S_GRANT    = 3'd3;
  localparam logic [2:0] S_MASTER   = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  localparam logic [9:0] TMO_LAST = 10'(GNT_TIMEOUT - 1);

  // Raw pins {rply, sync, sack, dmr}, still active low while in the chain.
  logic [3:0] pins_raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic       dmr_s, sack_s, sync_s, rply_s;

  assign pins_raw = {bus.pin_rply_n, bus.pin_sync_n, bus.pin_sack_n, bus.pin_dmr_n};

  always_ff @(posedge pin_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= pins_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign dmr_s  = ~sync_q[SYNC_STAGES-1][0];
  assign sack_s = ~sync_q[SYNC_STAGES-1][1];
  assign sync_s = ~sync_q[SYNC_STAGES-1][2];
  assign rply_s = ~sync_q[SYNC_STAGES-1][3];

  logic [2:0] state_q, state_d;
  logic       fair_q, fair_d;
  logic       seen_q, seen_d;
  logic [9:0] tmr_q, tmr_d;
  logic       tmo_d;
  logic       dmgo_n_q, hold_q, bus_dis_q, act_q, tmo_q;

  always_comb begin
    state_d = state_q;
    fair_d  = fair_q;
    seen_d  = 1'b0;
    tmr_d   = '0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmr_s) state_d = fair_q ? S_FAIR : S_WAIT_CPU;
      end
      S_FAIR: begin
        // seen_q remembers that the CPU's own cycle started; leave once it has ended.
        fair_d = 1'b0;
        seen_d = seen_q | bus.cpu_busy;
        if (!bus.cpu_busy && (seen_q || !bus.cpu_req)) state_d = S_WAIT_CPU;
      end
      S_WAIT_CPU: begin
        if (!dmr_s)                         state_d = S_IDLE;
        else if (!bus.cpu_busy && !sync_s)  state_d = S_GRANT;
      end
      S_GRANT: begin
        tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 10'd1;
        if (sack_s) begin
          state_d = S_MASTER;
        end else if (!dmr_s) begin
          state_d = S_IDLE;
        end else if (tmr_q >= TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end
      S_MASTER: begin
        if (!sack_s) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!sync_s && !rply_s) begin
          state_d = S_IDLE;
          fair_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      fair_q    <= 1'b0;
      seen_q    <= 1'b0;
      tmr_q     <= '0;
      dmgo_n_q  <= 1'b1;
      hold_q    <= 1'b0;
      bus_dis_q <= 1'b0;
      act_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fair_q    <= fair_d;
      seen_q    <= seen_d;
      tmr_q     <= tmr_d;
      dmgo_n_q  <= (state_d != S_GRANT);
      hold_q    <= state_d inside {S_WAIT_CPU, S_GRANT, S_MASTER, S_RELEASE};
      bus_dis_q <= state_d inside {S_GRANT, S_MASTER, S_RELEASE};
      act_q     <= state_d inside {S_MASTER, S_RELEASE};
      tmo_q     <= tmo_d;
    end
  end

  assign bus.pin_dmgo_n  = dmgo_n_q;
  assign bus.cpu_hold    = hold_q;
  assign bus.cpu_bus_dis = bus_dis_q;
  assign bus.dma_act     = act_q;
  assign bus.gnt_tmo     = tmo_q;

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Directed/randomized bench for qbus_dma_arb; expected latencies come from the pin-level timing rules.
module tb_qbus_dma_arb;

  logic pin_clk = 1'b0;
  logic reset;

  qbus_dma_arb_if bus ();

  qbus_dma_arb #(
    .SYNC_STAGES (2),
    .GNT_TIMEOUT (8)
  ) dut (
    .pin_clk (pin_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 pin_clk = ~pin_clk;

  int tests = 0;
  int fails = 0;
  int tmo_pulses = 0;

  always @(negedge pin_clk) if (bus.gnt_tmo === 1'b1) tmo_pulses++;

  localparam int SIG_DMGO_N = 0;
  localparam int SIG_HOLD   = 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pin_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int idx);
    case (idx)
      SIG_DMGO_N: return bus.pin_dmgo_n;
      default:    return bus.cpu_hold;
    endcase
  endfunction

  // Ticks until the selected output reaches val; returns bound if it never does.
  task automatic wait_sig(input int idx, input logic val, input int bound, output int n);
    n = 0;
    while (sig(idx) !== val && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dmgo_n"},  bus.pin_dmgo_n,  1);
    chk({tag, "_hold"},    bus.cpu_hold,    0);
    chk({tag, "_bus_dis"}, bus.cpu_bus_dis, 0);
    chk({tag, "_dma_act"}, bus.dma_act,     0);
    chk({tag, "_gnt_tmo"}, bus.gnt_tmo,     0);
  endtask

  initial begin
    int  n, d, m, r, b, p0, sel, exp_rel;
    bit  fair_m;

    bus.cpu_busy   = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.pin_dmr_n  = 1'b1;
    bus.pin_sack_n = 1'b1;
    bus.pin_sync_n = 1'b1;
    bus.pin_rply_n = 1'b1;
    reset = 1'b1;
    tick(2);
    chk_reset_outputs("reset");
    reset  = 1'b0;
    fair_m = 1'b0;
    tick(2);

    // CPU cycle in progress, then request withdrawn two cycles into GRANT.
    bus.cpu_busy = 1'b1;
    tick(1);
    b = $urandom_range(4, 12);
    bus.pin_dmr_n = 1'b0;
    for (int i = 1; i <= b; i++) begin
      tick(1);
      if (i >= 3) chk("busy_hold", bus.cpu_hold, 1);
      chk("busy_no_grant", bus.pin_dmgo_n, 1);
    end
    bus.cpu_busy = 1'b0;
    wait_sig(SIG_DMGO_N, 1'b0, 8, n);
    chk("busy_grant_lat", n, 1);
    chk("grant_bus_dis", bus.cpu_bus_dis, 1);
    chk("grant_hold", bus.cpu_hold, 1);
    p0 = tmo_pulses;
    tick(2);
    bus.pin_dmr_n = 1'b1;
    wait_sig(SIG_DMGO_N, 1'b1, 8, n);
    chk("withdraw_lat", n, 2 + 1);
    chk("withdraw_hold", bus.cpu_hold, 0);
    chk("withdraw_bus_dis", bus.cpu_bus_dis, 0);
    tick(2);
    chk("withdraw_no_tmo", tmo_pulses - p0, 0);

    // Grant timeout with DMR held and no SACK.
    tick(2);
    bus.pin_dmr_n = 1'b0;
    wait_sig(SIG_DMGO_N, 1'b0, 10, n);
    chk("tmo_grant_lat", n, 4);
    p0 = tmo_pulses;
    wait_sig(SIG_DMGO_N, 1'b1, 20, n);
    chk("tmo_dmgo_low_cycles", n, 8);
    chk("tmo_pulse_now", bus.gnt_tmo, 1);
    chk("tmo_idle_hold", bus.cpu_hold, 0);
    wait_sig(SIG_DMGO_N, 1'b0, 10, n);
    chk("tmo_regrant_no_fair", n, 2);
    chk("tmo_pulse_single", tmo_pulses - p0, 1);
    bus.pin_dmr_n = 1'b1;
    wait_sig(SIG_DMGO_N, 1'b1, 8, n);
    chk("tmo_withdraw_lat", n, 3);

    // Randomized complete DMA transfers; model tracks the fairness flag.
    for (int k = 0; k < 6; k++) begin
      tick(3);
      d   = (k == 0) ? 5 : $urandom_range(0, 5);
      m   = (k == 0) ? 20 : $urandom_range(2, 20);
      r   = $urandom_range(0, 4);
      sel = $urandom_range(0, 1);
      bus.pin_dmr_n = 1'b0;
      wait_sig(SIG_DMGO_N, 1'b0, 12, n);
      chk("grant_lat", n, fair_m ? 5 : 4);
      fair_m = 1'b0;
      tick(d);
      bus.pin_sack_n = 1'b0;
      bus.pin_dmr_n  = 1'b1;
      if (sel == 0) bus.pin_sync_n = 1'b0;
      else          bus.pin_rply_n = 1'b0;
      wait_sig(SIG_DMGO_N, 1'b1, 8, n);
      chk("sack_lat", n, 3);
      chk("master_act", bus.dma_act, 1);
      chk("master_hold", bus.cpu_hold, 1);
      chk("master_bus_dis", bus.cpu_bus_dis, 1);
      chk("master_no_tmo", bus.gnt_tmo, 0);
      tick(m);
      chk("master_dmgo_stays", bus.pin_dmgo_n, 1);
      chk("master_act_stays", bus.dma_act, 1);
      bus.pin_sack_n = 1'b1;
      n = 0;
      while (bus.cpu_hold !== 1'b0 && n < 16) begin
        if (n == r) begin
          bus.pin_sync_n = 1'b1;
          bus.pin_rply_n = 1'b1;
        end
        tick(1);
        n++;
      end
      exp_rel = (r + 3 > 4) ? r + 3 : 4;
      chk("release_lat", n, exp_rel);
      chk("release_act", bus.dma_act, 0);
      chk("release_bus_dis", bus.cpu_bus_dis, 0);
      bus.pin_sync_n = 1'b1;
      bus.pin_rply_n = 1'b1;
      fair_m = 1'b1;
    end

    // Fairness: DMR held across the release while the CPU has a cycle pending.
    tick(3);
    bus.pin_dmr_n = 1'b0;
    wait_sig(SIG_DMGO_N, 1'b0, 12, n);
    chk("fair_grant_lat", n, fair_m ? 5 : 4);
    tick(1);
    bus.pin_sack_n = 1'b0;
    wait_sig(SIG_DMGO_N, 1'b1, 8, n);
    chk("fair_sack_lat", n, 3);
    tick(3);
    chk("master_ignores_dmr", bus.pin_dmgo_n, 1);
    bus.cpu_req    = 1'b1;
    bus.pin_sack_n = 1'b1;
    wait_sig(SIG_HOLD, 1'b0, 10, n);
    chk("fair_release_lat", n, 4);
    b = $urandom_range(2, 5);
    bus.cpu_busy = 1'b1;
    for (int i = 1; i <= b; i++) begin
      tick(1);
      chk("fair_hold_low", bus.cpu_hold, 0);
      chk("fair_no_grant", bus.pin_dmgo_n, 1);
    end
    bus.cpu_busy = 1'b0;
    bus.cpu_req  = 1'b0;
    wait_sig(SIG_HOLD, 1'b1, 6, n);
    chk("fair_hold_rise", n, 1);
    wait_sig(SIG_DMGO_N, 1'b0, 6, n);
    chk("fair_regrant", n, 1);

    // Reset while a master owns the bus.
    bus.pin_sack_n = 1'b0;
    bus.pin_dmr_n  = 1'b1;
    wait_sig(SIG_DMGO_N, 1'b1, 8, n);
    chk("rstm_sack_lat", n, 3);
    chk("rstm_in_master", bus.dma_act, 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_reset_outputs("rst_master");
    reset = 1'b0;
    bus.pin_sack_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rstm_no_dmgo", bus.pin_dmgo_n, 1);
      chk("rstm_no_hold", bus.cpu_hold, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qbus_dma_arb.md
# qbus_dma_arb

Q-bus DMA arbiter for the F-11 processor wrapper. It decides when the CPU bus interface gives up the Q-bus to an external DMA master, using the Q-bus handshake: DMR request, DMGO grant, SACK acknowledge. It stalls the CPU between bus cycles, releases the address/data drivers, and returns the bus once the DMA master has finished. It sits next to the bus-cycle/SYNC logic and drives a hold input into the CPU clock-stretch (qwait) term.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer on every asynchronous pin (minimum 2).
- GNT_TIMEOUT, 64: number of pin_clk cycles DMGO may stay asserted without SACK before the grant is withdrawn (range 2..1023).

Ports:
- pin_clk, in, 1: clock, rising edge.
- reset, in, 1: reset, synchronous, active-high.
- cpu_busy, in, 1: CPU bus cycle in progress (SYNC driven by the CPU).
- cpu_req, in, 1: CPU has a bus cycle pending at the next mce_n.
- cpu_hold, out, 1: when high, the CPU must not start a new bus cycle; OR'd into qwait.
- cpu_bus_dis, out, 1: CPU tri-states AD, A, BS, SYNC, DIN, DOUT and WTBT.
- pin_dmr_n, in, 1: DMA request, active low, asynchronous.
- pin_sack_n, in, 1: selection acknowledge, active low, asynchronous.
- pin_sync_n, in, 1: bus SYNC, active low, asynchronous.
- pin_rply_n, in, 1: bus RPLY, active low, asynchronous.
- pin_dmgo_n, out, 1: DMA grant out, active low, registered.
- dma_act, out, 1: a DMA master owns the bus (state MASTER or RELEASE).
- gnt_tmo, out, 1: one-cycle pulse when a grant is withdrawn by timeout.

## Operation

- Each asynchronous pin passes through a SYNC_STAGES synchronizer and is inverted. The results are dmr_s, sack_s, sync_s and rply_s, all active high. The FSM uses only these synchronized signals.
- States are IDLE, FAIR, WAIT_CPU, GRANT, MASTER and RELEASE. Encoding is free.
- IDLE:
  - dmr_s and fair_pend=0 -> WAIT_CPU.
  - dmr_s and fair_pend=1 -> FAIR.
- FAIR: cpu_hold stays low so the CPU gets one bus cycle.
  - Exit to WAIT_CPU once cpu_busy has been seen high and then low, or immediately if cpu_req=0.
  - Clears fair_pend.
- WAIT_CPU: cpu_hold=1.
  - Minimum residency is 1 cycle.
  - -> GRANT when cpu_busy=0 and sync_s=0.
  - If dmr_s drops before that -> IDLE (hold released, no grant).
- GRANT: DMGO asserted, cpu_bus_dis=1, grant timer counts.
  - sack_s -> MASTER.
  - dmr_s=0 and sack_s=0 -> IDLE (request withdrawn).
  - Timer reaches GNT_TIMEOUT-1 -> IDLE, with gnt_tmo pulsed for 1 cycle.
  - sack_s takes priority over both the withdrawal and the timeout in the same cycle.
- MASTER: DMGO negated, cpu_hold=1, cpu_bus_dis=1. -> RELEASE when sack_s=0.
- RELEASE: -> IDLE when sync_s=0 and rply_s=0. Sets fair_pend=1.
- The grant timer is 10-bit, cleared in every state except GRANT, and saturates.
- cpu_hold is high in WAIT_CPU, GRANT, MASTER and RELEASE.
- cpu_bus_dis is high in GRANT, MASTER and RELEASE.
- A new DMR arriving while in MASTER is ignored until IDLE. Chained masters are arbitrated through FAIR.

## Timing

- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: pin_dmgo_n=1, cpu_hold=0, cpu_bus_dis=0, dma_act=0, gnt_tmo=0. State=IDLE, fair_pend=0, timer=0, synchronizers=negated.
- Reset asserted mid-operation returns to IDLE on the next edge and negates DMGO and hold in that same cycle.
- Latency with SYNC_STAGES=2 and CPU idle:
  - pin_dmr_n falls before edge N; dmr_s is high after edge N+1.
  - WAIT_CPU (cpu_hold=1) after edge N+2.
  - GRANT (pin_dmgo_n=0) after edge N+3.
- SACK to DMGO negation: pin_sack_n low before edge M gives MASTER and pin_dmgo_n=1 after edge M+2.
- cpu_hold must reach the CPU before the next mce_n. The CPU side guarantees that a cycle started in the hold-assertion cycle is visible on cpu_busy one cycle later. This is why WAIT_CPU has its 1-cycle minimum residency.

## Test plan

- Basic grant:
  - Stimulus: CPU idle; pin_dmr_n low at cycle 0; bench drives pin_sack_n low 5 cycles after DMGO falls and high 20 cycles later, with sync/rply idle.
  - Required: DMGO low at cycle 3; high 2 cycles after SACK low; cpu_hold low 3 cycles after SACK high; dma_act high from MASTER entry to IDLE.
- CPU cycle in progress:
  - Stimulus: cpu_busy high for 10 cycles from before DMR.
  - Required: cpu_hold=1 throughout the wait; DMGO falls exactly 1 cycle after cpu_busy falls.
- Timeout:
  - Stimulus: GNT_TIMEOUT=8, DMR held low, no SACK.
  - Required: DMGO low for 8 cycles; gnt_tmo single pulse; state IDLE; the next arbitration starts without FAIR.
- Withdrawal:
  - Stimulus: DMR released 2 cycles into GRANT.
  - Required: DMGO high 2 cycles after the pin change; no gnt_tmo.
- Fairness:
  - Stimulus: DMR held low across release with cpu_req=1.
  - Required: cpu_hold drops; CPU completes one cycle (cpu_busy pulse); then cpu_hold rises and DMGO is reasserted.
- Reset in MASTER:
  - Stimulus: assert reset for 1 cycle.
  - Required: after the edge, all outputs return to their reset values; no DMGO glitch in the following 3 cycles while DMR is high.
